// File: rtl/fc_stream_pkg.sv
// Shared types and defaults for the FC layer streaming driver.
// Holds the run-state encoding, the default layer geometry and the
// saturating latency-counter helper.
package fc_stream_pkg;

   // Default layer geometry: M results, N input elements, T-bit signed data.
   localparam int FC_M  = 16;
   localparam int FC_N  = 8;
   localparam int FC_T  = 16;

   // Width of the run latency counter and of the reported lat_cycles value.
   localparam int LAT_W = 16;

   // Run sequencing: load in IDLE, stream the vector, gather results, report.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } fc_state_t;

   // Increment that sticks at all-ones so a very long run reports the maximum
   // instead of wrapping to a small, misleading number.
   function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
      logic [LAT_W-1:0] r;
      if (v == {LAT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fc_result_buffer.sv
// Result storage for one run: DEPTH x WIDTH, one synchronous write port and
// one registered read port. A read of the address being written in the same
// cycle returns the value stored before that write.
module fc_result_buffer
#(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   // Storage itself is deliberately left without reset; only the read
   // register has a defined value after reset.
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   // Read mux: selects the stored word for the presented address.
   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   // Write port: the result lands at the handshake edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read register: one cycle of latency, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_stream_driver.sv
// Initiator-side driver for one fully-connected layer core. The host loads an
// N-element vector while idle and pulses start; the driver streams the vector
// into the layer, gathers M results into a buffer, pulses done and reports the
// number of cycles the run took.
//
// Stream handshake (both ports): a word moves on a rising edge where valid and
// ready are both high. valid is raised from registered state only and never
// waits for ready; once raised, the word stays stable until it is accepted.
// The layer may compute its ready from our valid combinationally.
module fc_stream_driver
   import fc_stream_pkg::*;
#(
   parameter  int M    = FC_M,
   parameter  int N    = FC_N,
   parameter  int T    = FC_T,
   localparam int AW_N = (N > 1) ? $clog2(N) : 1,
   localparam int AW_M = (M > 1) ? $clog2(M) : 1
)(
   input  logic             clk,
   input  logic             reset,
   // host side
   input  logic             host_wr_en,
   input  logic [AW_N-1:0]  host_wr_addr,
   input  logic [T-1:0]     host_wr_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             protocol_err,
   output logic [LAT_W-1:0] lat_cycles,
   // layer input stream
   output logic             s_valid,
   input  logic             s_ready,
   output logic [T-1:0]     s_data,
   // layer output stream
   input  logic             r_valid,
   output logic             r_ready,
   input  logic [T-1:0]     r_data,
   // result readback
   input  logic [AW_M-1:0]  rd_addr,
   output logic [T-1:0]     rd_data,
   // run state, exported for observation
   output fc_state_t        dbg_state
);

   localparam logic [AW_N-1:0] SEND_LAST = AW_N'(N - 1);
   localparam logic [AW_M-1:0] RECV_LAST = AW_M'(M - 1);

   fc_state_t        state_q, state_d;
   logic [T-1:0]     vec_q [N];
   logic [T-1:0]     vec_d [N];
   logic [AW_N-1:0]  send_cnt_q, send_cnt_d;
   logic [AW_M-1:0]  recv_cnt_q, recv_cnt_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [LAT_W-1:0] lat_cycles_q, lat_cycles_d;
   logic [LAT_W-1:0] lat_inc;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             s_valid_q, s_valid_d;
   logic             r_ready_q, r_ready_d;
   logic             protocol_err_q, protocol_err_d;
   logic             s_fire;
   logic             r_fire;
   logic             res_wr_en;

   assign lat_inc = lat_sat_inc(lat_cnt_q);
   assign s_fire  = s_valid_q & s_ready;
   assign r_fire  = r_ready_q & r_valid;

   // Next-state logic: sequencing, counters, vector writes, sticky error and
   // the registered handshake/status outputs derived from the next state.
   always_comb begin
      state_d        = state_q;
      vec_d          = vec_q;
      send_cnt_d     = send_cnt_q;
      recv_cnt_d     = recv_cnt_q;
      lat_cnt_d      = lat_cnt_q;
      lat_cycles_d   = lat_cycles_q;
      protocol_err_d = protocol_err_q;
      res_wr_en      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The vector is only writable while no run is using it.
            if (host_wr_en) begin
               vec_d[host_wr_addr] = host_wr_data;
            end
            if (start) begin
               state_d        = SEND;
               send_cnt_d     = '0;
               recv_cnt_d     = '0;
               lat_cnt_d      = '0;
               protocol_err_d = 1'b0;
            end
         end
         SEND: begin
            lat_cnt_d = lat_inc;
            if (s_fire) begin
               if (send_cnt_q == SEND_LAST) begin
                  send_cnt_d = '0;
                  state_d    = COLLECT;
               end else begin
                  send_cnt_d = send_cnt_q + 1'b1;
               end
            end
         end
         COLLECT: begin
            lat_cnt_d = lat_inc;
            if (r_fire) begin
               res_wr_en = 1'b1;
               if (recv_cnt_q == RECV_LAST) begin
                  recv_cnt_d   = '0;
                  state_d      = DONE;
                  // Capture including this final cycle so lat_cycles is
                  // already valid while done is high.
                  lat_cycles_d = lat_inc;
               end else begin
                  recv_cnt_d = recv_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A layer result offered while we are not collecting is dropped and
      // flagged; the flag outlives the run until the next accepted start.
      if (r_valid && (state_q != COLLECT)) begin
         protocol_err_d = 1'b1;
      end

      busy_d    = (state_d == SEND) || (state_d == COLLECT);
      done_d    = (state_d == DONE);
      s_valid_d = (state_d == SEND);
      r_ready_d = (state_d == COLLECT);
   end

   // State and output registers; reset aborts any run in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         send_cnt_q     <= '0;
         recv_cnt_q     <= '0;
         lat_cnt_q      <= '0;
         lat_cycles_q   <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         s_valid_q      <= 1'b0;
         r_ready_q      <= 1'b0;
         protocol_err_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            vec_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         send_cnt_q     <= send_cnt_d;
         recv_cnt_q     <= recv_cnt_d;
         lat_cnt_q      <= lat_cnt_d;
         lat_cycles_q   <= lat_cycles_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         s_valid_q      <= s_valid_d;
         r_ready_q      <= r_ready_d;
         protocol_err_q <= protocol_err_d;
         vec_q          <= vec_d;
      end
   end

   // Element toward the layer comes straight from the vector registers, so it
   // is stable for as long as send_cnt holds during a stall.
   assign s_data       = vec_q[send_cnt_q];
   assign s_valid      = s_valid_q;
   assign r_ready      = r_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign protocol_err = protocol_err_q;
   assign lat_cycles   = lat_cycles_q;
   assign dbg_state    = state_q;

   fc_result_buffer #(
      .DEPTH (M),
      .WIDTH (T)
   ) u_result_buffer (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (res_wr_en),
      .wr_addr (recv_cnt_q),
      .wr_data (r_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fc_stream_driver.sv
// Directed bench for fc_stream_driver with a cycle-level layer model.
// Expected vector elements are queued when a run starts and popped as the
// layer accepts them; results handed to the driver are recorded and read back.
module tb_fc_stream_driver;
   import fc_stream_pkg::*;

   localparam int M = 16;
   localparam int N = 8;
   localparam int T = 16;

   // clock / reset
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // DUT connections
   logic         host_wr_en   = 1'b0;
   logic [2:0]   host_wr_addr = '0;
   logic [T-1:0] host_wr_data = '0;
   logic         start        = 1'b0;
   logic         s_ready      = 1'b0;
   logic         r_valid      = 1'b0;
   logic [T-1:0] r_data       = '0;
   logic [3:0]   rd_addr      = '0;
   logic         busy, done, protocol_err, s_valid, r_ready;
   logic [15:0]  lat_cycles;
   logic [T-1:0] s_data, rd_data;
   fc_state_t    dbg_state;

   fc_stream_driver dut (
      .clk          (clk),
      .reset        (reset),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .protocol_err (protocol_err),
      .lat_cycles   (lat_cycles),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_data       (r_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .dbg_state    (dbg_state)
   );

   // scoreboard and layer-model state
   int           total = 0;
   int           bad   = 0;
   logic [T-1:0] exp_q [$];
   logic [T-1:0] vec_model [N];
   logic [T-1:0] res_model [M];
   logic [T-1:0] sent_log  [N];
   int           in_cnt, out_cnt;
   int           stall_at   = -1;
   int           stall_len  = 0;
   int           stall_left = 0;
   int           start_cyc, done_cnt, done_cyc;
   int           res_base   = 100;
   bit           res_rand   = 1'b0;
   bit           sparse     = 1'b0;
   bit           phase      = 1'b1;
   bit           force_rv   = 1'b0;

   function automatic int cyc_now();
      return int'($time / 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: at the falling edge, check what the DUT shows and drive
   // the layer side for the coming rising edge.
   task automatic tick();
      int           cyc;
      logic [31:0]  want;
      bit           give;
      @(negedge clk);
      cyc = cyc_now();
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         chk("busy_low_at_done", 32'(busy), 32'd0);
      end
      // layer input port
      if (s_valid === 1'b1) begin
         if (in_cnt == stall_at && stall_left > 0) begin
            s_ready = 1'b0;
            stall_left--;
            want = (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hdead_beef;
            chk("s_data_hold", 32'(s_data), want);
         end else begin
            s_ready = 1'b1;
            if (exp_q.size() != 0) want = 32'(exp_q.pop_front());
            else                   want = 32'hdead_beef;
            chk("s_data", 32'(s_data), want);
            chk("s_elem_time", 32'(cyc), 32'(start_cyc + 1 + in_cnt + (stall_len - stall_left)));
            if (in_cnt < N) sent_log[in_cnt] = s_data;
            in_cnt++;
         end
      end else begin
         s_ready = 1'($urandom_range(0, 1));
      end
      // layer output port
      if (force_rv) begin
         r_valid = 1'b1;
         r_data  = 16'h5a5a;
         chk("r_ready_outside_collect", 32'(r_ready), 32'd0);
      end else if (r_ready === 1'b1) begin
         give  = sparse ? phase : 1'b1;
         phase = ~phase;
         if (give) begin
            r_valid = 1'b1;
            r_data  = res_rand ? 16'($urandom_range(0, 65535)) : 16'(res_base + out_cnt);
            if (out_cnt < M) res_model[out_cnt] = r_data;
            out_cnt++;
         end else begin
            r_valid = 1'b0;
            r_data  = 16'($urandom_range(0, 65535));
         end
      end else begin
         r_valid = 1'b0;
      end
   endtask

   task automatic host_write(input int addr, input logic [T-1:0] data, input bit in_idle);
      host_wr_en   = 1'b1;
      host_wr_addr = 3'(addr);
      host_wr_data = data;
      tick();
      host_wr_en   = 1'b0;
      if (in_idle) vec_model[addr] = data;
   endtask

   task automatic arm_run();
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(vec_model[i]);
      in_cnt     = 0;
      out_cnt    = 0;
      phase      = 1'b1;
      stall_left = stall_len;
      done_cnt   = 0;
      done_cyc   = -1;
      start_cyc  = cyc_now();
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Full run: start, optional guard pokes during SEND, wait for done, then
   // check timing, latency and every stored result.
   task automatic run(input int exp_lat, input bit guard);
      arm_run();
      chk("s_valid_first_cycle", 32'(s_valid), 32'd1);
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("perr_cleared_by_start", 32'(protocol_err), 32'd0);
      if (guard) begin
         start        = 1'b1;
         host_wr_en   = 1'b1;
         host_wr_addr = 3'd2;
         host_wr_data = 16'h8000;
         tick();
         start        = 1'b0;
         host_wr_en   = 1'b0;
      end
      for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
      chk("done_seen", 32'(done_cnt), 32'd1);
      chk("done_time", 32'(done_cyc), 32'(start_cyc + exp_lat + 1));
      chk("lat_cycles", 32'(lat_cycles), 32'(exp_lat));
      tick();
      tick();
      chk("done_single_pulse", 32'(done_cnt), 32'd1);
      chk("busy_after_run", 32'(busy), 32'd0);
      chk("elements_sent", 32'(in_cnt), 32'(N));
      chk("results_taken", 32'(out_cnt), 32'(M));
      chk("perr_clean_run", 32'(protocol_err), 32'd0);
      chk("lat_cycles_hold", 32'(lat_cycles), 32'(exp_lat));
      for (int i = 0; i < M; i++) begin
         rd_addr = 4'(i);
         tick();
         chk("rd_data", 32'(rd_data), 32'(res_model[i]));
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) vec_model[i] = '0;

      // reset state
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_r_ready", 32'(r_ready), 32'd0);
      chk("rst_perr", 32'(protocol_err), 32'd0);
      chk("rst_lat", 32'(lat_cycles), 32'd0);
      chk("rst_s_data", 32'(s_data), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);

      // basic run: vector 1..8, results 100..115 back to back
      for (int i = 0; i < N; i++) host_write(i, 16'(i + 1), 1'b1);
      run(N + M, 1'b0);

      // input backpressure: three stall cycles while element 4 (value 5) waits
      stall_at  = 4;
      stall_len = 3;
      res_rand  = 1'b1;
      run(N + M + 3, 1'b0);
      stall_at  = -1;
      stall_len = 0;

      // sparse results: r_valid every other cycle
      sparse = 1'b1;
      run(N + 31, 1'b0);
      sparse = 1'b0;

      // spurious result while idle
      tick();
      force_rv = 1'b1;
      tick();
      force_rv = 1'b0;
      tick();
      chk("perr_set_idle", 32'(protocol_err), 32'd1);
      repeat (3) tick();
      chk("perr_sticky", 32'(protocol_err), 32'd1);
      run(N + M, 1'b0);

      // start and vector write during SEND are ignored
      run(N + M, 1'b1);
      chk("guard_vec2_kept", 32'(sent_log[2]), 32'd3);
      host_write(2, 16'h8000, 1'b1);
      run(N + M, 1'b0);
      chk("neg_full_scale_sent", 32'(sent_log[2]), 32'h8000);

      // reset after three SEND handshakes
      for (int i = 0; i < N; i++) host_write(i, 16'($urandom_range(0, 65535)), 1'b1);
      arm_run();
      for (int i = 0; i < 20 && in_cnt < 3; i++) tick();
      @(negedge clk);
      s_ready = 1'b0;
      r_valid = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      chk("abort_s_valid", 32'(s_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_vec_cleared", 32'(s_data), 32'd0);
      chk("abort_state", 32'(dbg_state), 32'(IDLE));
      for (int i = 0; i < N; i++) vec_model[i] = '0;
      for (int i = 0; i < N; i++) host_write(i, 16'($urandom_range(0, 65535)), 1'b1);
      run(N + M, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fc_stream_driver.md
# fc_stream_driver

Initiator-side streaming driver for a fully-connected layer core (M outputs, N inputs, T-bit signed). A host loads an N-element input vector and pulses `start`. The block then streams the vector into the layer's valid/ready input port, collects the M results from the layer's valid/ready output port into a result buffer, and reports completion and measured latency. It sits between host/test logic and one FC layer instance, owning both ends of that layer's stream protocol.

## Interface
- `M`, 16, number of layer outputs collected per run
- `N`, 8, number of vector elements sent per run
- `T`, 16, data width, two's-complement signed
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `host_wr_en`  in  1  write enable for one vector element
- `host_wr_addr`  in  $clog2(N)  vector element index
- `host_wr_data`  in  T  vector element value
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high in SEND and COLLECT
- `done`  out  1  one-cycle pulse when the M-th result is stored
- `protocol_err`  out  1  sticky flag for a layer output seen outside COLLECT
- `lat_cycles`  out  16  cycles from the first SEND cycle to the final result handshake, saturating
- `s_valid`  out  1  element valid toward the layer
- `s_ready`  in  1  layer accepts the element
- `s_data`  out  T  element toward the layer
- `r_valid`  in  1  layer result valid
- `r_ready`  out  1  driver accepts the result
- `r_data`  in  T  layer result
- `rd_addr`  in  $clog2(M)  result buffer read index
- `rd_data`  out  T  result buffer read data, registered

## Operation
- States: IDLE, SEND, COLLECT, DONE.
- IDLE:
  - A `host_wr_en` write lands in `vec[host_wr_addr]` at the clock edge. Writes in any other state are ignored.
  - `start` moves to SEND. It clears `send_cnt`, `recv_cnt`, the latency counter and `protocol_err`.
- SEND:
  - `s_valid` = 1 and `s_data` = `vec[send_cnt]`. Both come from registers and muxes only; `s_valid` never depends on `s_ready` (the layer's ready may be combinational on valid).
  - A transfer occurs when `s_valid` and `s_ready` are both high; `send_cnt` then increments.
  - After the N-th transfer, go to COLLECT.
  - `s_data` stays stable while stalled.
- COLLECT:
  - `r_ready` = 1.
  - On `r_valid`, store `r_data` in `result[recv_cnt]` and increment `recv_cnt`.
  - After the M-th transfer, go to DONE.
- DONE: `done` = 1 for exactly one cycle, `lat_cycles` is latched, then go to IDLE.
- `r_ready` = 0 in IDLE, SEND and DONE. `r_valid` = 1 in those states sets `protocol_err` (sticky until the next accepted `start`). The data is dropped.
- `start` outside IDLE is ignored.
- Data passes unmodified: no saturation or rounding; full signed range including -2^(T-1).
- Latency counter:
  - Increments every cycle in SEND and COLLECT, saturating at 65535.
  - `lat_cycles` holds its last latched value until the next DONE.
- Reset values:
  - state = IDLE; `busy`, `done`, `s_valid`, `r_ready`, `protocol_err` = 0.
  - `lat_cycles` = 0; `s_data` = 0; `vec` all 0; `rd_data` = 0.
  - The result buffer is not reset.
- Reset mid-run aborts immediately. The next `start` resends from element 0.

## Timing
- `start` sampled high at edge k: SEND from cycle k+1, with `s_valid` high that cycle.
- With `s_ready` held at 1: elements 0..N-1 on cycles k+1..k+N, COLLECT from k+N+1.
- `done` is high the cycle after the final result handshake. `busy` drops the same cycle `done` rises.
- Result buffer:
  - Write at the handshake edge.
  - `rd_data` = `result[rd_addr]` one cycle after `rd_addr` is presented.
  - Read and write of the same address in the same cycle returns the old value.
- Minimum run (no stalls): `lat_cycles` = N + M.

## Structure
- Package `fc_stream_pkg`: state enum typedef (IDLE, SEND, COLLECT, DONE), default M/N/T localparams, latency counter width 16.
- Sub-module `fc_result_buffer`: M x T, single synchronous write port, registered read port.
- Vector storage is an N x T register array inside the top level, so `s_data` is available in the same cycle.

## Test plan
- Basic run: vec = 1..8, layer model with `s_ready`=1 returning 100..115 back-to-back. Required: `s_data` = 1..8 on cycles k+1..k+8, one `done` pulse, `lat_cycles` = 24, `rd_addr` 0..15 reads 100..115.
- Input backpressure: `s_ready` = 0 for 3 cycles while `send_cnt` = 4. Required: `s_data` holds 5 throughout, no element skipped or duplicated, `lat_cycles` = 27.
- Sparse results: `r_valid` every other cycle. Required: all 16 results stored in order, `done` after the 16th, `lat_cycles` = 8 + 31.
- Spurious `r_valid` in IDLE. Required: `r_ready` = 0, `protocol_err` = 1 and stays 1; the next `start` clears it.
- Reset after 3 SEND handshakes. Required: next cycle `s_valid` = 0, `busy` = 0, `vec` = 0. After reloading and `start`, element 0 is sent first.
- Guard cases: `start` and `host_wr_en` (addr 2, value -32768) during SEND are both ignored; `vec[2]` is unchanged. A later IDLE write of -32768 is sent and observed as 0x8000.
